// File: rtl/jamma_pkg.sv
// Shared constants, FSM state type and the chain slot -> joystick bit map
// for the JAMMA/DB9 joystick reader.
package jamma_pkg;

    // First and last chain slots that carry joystick data.
    localparam int SLOT_FIRST = 2;
    localparam int SLOT_LAST  = 25;

    // Data bits captured per frame and bits per player word.
    localparam int FRAME_BITS = SLOT_LAST - SLOT_FIRST + 1;
    localparam int JOY_BITS   = 12;

    // Idle / reset value of a player word: nothing pressed (active-low).
    localparam logic [JOY_BITS-1:0] JOY_RESET_WORD = 12'hFFF;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_PRELOAD,
        ST_SHIFT,
        ST_COMMIT
    } reader_state_t;

    // Destination of one chain slot: which player word and which bit in it.
    typedef struct packed {
        logic       valid;
        logic       player;
        logic [3:0] bit_idx;
    } joy_bit_t;

    // Board wiring of the shift-register chain. Slots 0 and 1 carry no data.
    function automatic joy_bit_t slot_to_bit(input logic [4:0] slot);
        joy_bit_t m;
        m.valid   = 1'b1;
        m.bit_idx = 4'd0;
        case (slot)
            5'd2,  5'd10: m.bit_idx = 4'd8;
            5'd3,  5'd11: m.bit_idx = 4'd6;
            5'd4,  5'd12: m.bit_idx = 4'd5;
            5'd5,  5'd13: m.bit_idx = 4'd4;
            5'd6,  5'd14: m.bit_idx = 4'd3;
            5'd7,  5'd15: m.bit_idx = 4'd2;
            5'd8,  5'd16: m.bit_idx = 4'd1;
            5'd9,  5'd17: m.bit_idx = 4'd0;
            5'd18, 5'd22: m.bit_idx = 4'd10;
            5'd19, 5'd23: m.bit_idx = 4'd11;
            5'd20, 5'd24: m.bit_idx = 4'd9;
            5'd21, 5'd25: m.bit_idx = 4'd7;
            default:      m.valid   = 1'b0;
        endcase
        // Slots 10..21 belong to player 2, everything else to player 1.
        m.player = (slot >= 5'd10) && (slot <= 5'd21);
        return m;
    endfunction

    // Position in the 24-bit raw frame: player 1 in [11:0], player 2 in [23:12].
    function automatic logic [4:0] raw_index(input joy_bit_t m);
        return m.player ? (5'(JOY_BITS) + {1'b0, m.bit_idx}) : {1'b0, m.bit_idx};
    endfunction

endpackage

// File: rtl/bit_debounce.sv
// Single-bit frame-based debouncer: a new value is accepted only after it
// has differed from the output on DEB_FRAMES consecutive commits.
module bit_debounce #(
    parameter int   DEB_FRAMES  = 3,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk12,
    input  logic rst_n,
    input  logic commit_en,
    input  logic raw_bit,
    output logic deb_bit
);

    localparam logic [2:0] COUNT_LAST = 3'(DEB_FRAMES - 1);

    logic [2:0] count;

    // Per-commit persistence counter and the debounced output bit.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            deb_bit <= RESET_VALUE;
            count   <= 3'd0;
        end else if (commit_en) begin
            if (raw_bit == deb_bit) begin
                count <= 3'd0;
            end else if (count == COUNT_LAST) begin
                deb_bit <= raw_bit;
                count   <= 3'd0;
            end else begin
                count <= count + 3'd1;
            end
        end
    end

endmodule

// File: rtl/jamma_joy_reader.sv
// Serial reader for the JAMMA/DB9 joystick shift-register chain: generates
// load and shift clock, captures 24 bits per frame, debounces each bit and
// presents two active-low 12-bit player words.
module jamma_joy_reader
    import jamma_pkg::*;
#(
    parameter int CLK_DIV    = 28,
    parameter int DEB_FRAMES = 3
) (
    input  logic                clk12,
    input  logic                rst_n,
    output logic                joy_clk,
    output logic                joy_load,
    input  logic                joy_data,
    output logic [JOY_BITS-1:0] joystick1,
    output logic [JOY_BITS-1:0] joystick2,
    output logic                frame_done
);

    localparam int               PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [4:0]       SLOT_END = 5'(SLOT_LAST);

    logic                  data_meta;
    logic                  data_sync;
    logic [PRE_W-1:0]      pre_cnt;
    logic                  tick;
    logic                  fall_tick;
    logic [4:0]            slot;
    logic [4:0]            slot_nxt;
    reader_state_t         state;
    reader_state_t         state_nxt;
    logic                  sample_en;
    logic                  commit_en;
    joy_bit_t              slot_map;
    logic [FRAME_BITS-1:0] raw_frame;
    logic [FRAME_BITS-1:0] deb_frame;

    // Two-flop synchronizer for the asynchronous chain data.
    always_ff @(posedge clk12 or negedge rst_n) begin
        // NOTE: non-blocking assignments so each flop samples the value from before the edge.
        if (!rst_n) begin
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            data_meta <= joy_data;
            data_sync <= data_meta;
        end
    end

    // Free-running prescaler; a tick marks every joy_clk half-period.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign tick      = (pre_cnt == PRE_LAST);
    assign fall_tick = tick && joy_clk;

    // Shift clock toggles on every tick.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            joy_clk <= 1'b0;
        end else if (tick) begin
            joy_clk <= ~joy_clk;
        end
    end

    // Next slot: advances on each falling tick, wrapping after the last slot.
    always_comb begin
        slot_nxt = slot;
        if (fall_tick) begin
            slot_nxt = (slot == SLOT_END) ? 5'd0 : slot + 5'd1;
        end
    end

    // Slot register and load strobe, registered from the slot being entered.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            slot     <= 5'd0;
            joy_load <= 1'b0;
        end else begin
            slot     <= slot_nxt;
            joy_load <= (slot_nxt != 5'd0);
        end
    end

    // Frame sequencer state register.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencer next state and strobes.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_nxt = state;
        sample_en = 1'b0;
        commit_en = 1'b0;
        case (state)
            ST_LOAD: begin
                if (fall_tick) state_nxt = ST_PRELOAD;
            end
            ST_PRELOAD: begin
                if (fall_tick) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                sample_en = fall_tick;
                if (fall_tick && (slot == SLOT_END)) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit_en = 1'b1;
                state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    assign slot_map = slot_to_bit(slot);

    // Raw frame capture at the end of each data slot.
    always_ff @(posedge clk12 or negedge rst_n) begin
        // NOTE: the raw frame is a small register, not a memory, so it is reset to the idle pattern.
        if (!rst_n) begin
            raw_frame <= {JOY_RESET_WORD, JOY_RESET_WORD};
        end else if (sample_en && slot_map.valid) begin
            raw_frame[raw_index(slot_map)] <= data_sync;
        end
    end

    // Commit strobe delayed one cycle so it coincides with the new outputs.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= commit_en;
        end
    end

    for (genvar i = 0; i < FRAME_BITS; i++) begin : g_deb
        bit_debounce #(
            .DEB_FRAMES  (DEB_FRAMES),
            .RESET_VALUE (JOY_RESET_WORD[i % JOY_BITS])
        ) u_deb (
            .clk12     (clk12),
            .rst_n     (rst_n),
            .commit_en (commit_en),
            .raw_bit   (raw_frame[i]),
            .deb_bit   (deb_frame[i])
        );
    end

    assign joystick1 = deb_frame[JOY_BITS-1:0];
    assign joystick2 = deb_frame[FRAME_BITS-1:JOY_BITS];

endmodule

// File: tb/tb_jamma_joy_reader.sv
// Directed bench for jamma_joy_reader: one instance without debounce
// (DEB_FRAMES = 1) and one with DEB_FRAMES = 3, fed by a shared chain model.
module tb_jamma_joy_reader;

    localparam int CLK_DIV      = 28;
    localparam int FRAME_CYCLES = 52 * CLK_DIV;

    logic        clk12    = 1'b0;
    logic        rst_n    = 1'b0;
    logic        joy_data = 1'b1;
    logic        joy_clk_a, joy_load_a, frame_done_a;
    logic [11:0] joystick1_a, joystick2_a;
    logic        joy_clk_b, joy_load_b, frame_done_b;
    logic [11:0] joystick1_b, joystick2_b;

    int          n_cmp = 0;
    int          n_bad = 0;

    // Word the chain presents each frame; slot 2 is bit 23, slot 25 is bit 0.
    logic [23:0] frame_word = 24'hFFFFFF;
    int          m_slot     = 0;
    logic        jc_prev    = 1'b0;
    logic        data_pend  = 1'b0;
    logic [4:0]  bit_pos;

    always #5 clk12 = ~clk12;

    jamma_joy_reader #(.CLK_DIV(CLK_DIV), .DEB_FRAMES(1)) dut_a (
        .clk12      (clk12),
        .rst_n      (rst_n),
        .joy_clk    (joy_clk_a),
        .joy_load   (joy_load_a),
        .joy_data   (joy_data),
        .joystick1  (joystick1_a),
        .joystick2  (joystick2_a),
        .frame_done (frame_done_a)
    );

    jamma_joy_reader #(.CLK_DIV(CLK_DIV), .DEB_FRAMES(3)) dut_b (
        .clk12      (clk12),
        .rst_n      (rst_n),
        .joy_clk    (joy_clk_b),
        .joy_load   (joy_load_b),
        .joy_data   (joy_data),
        .joystick1  (joystick1_b),
        .joystick2  (joystick2_b),
        .frame_done (frame_done_b)
    );

    // Chain model: tracks slots from the shift clock and changes the data
    // line one cycle after each rising shift edge.
    initial begin
        forever begin
            @(posedge clk12);
            #1;
            if (!rst_n) begin
                m_slot    = 0;
                jc_prev   = 1'b0;
                data_pend = 1'b0;
                joy_data  = 1'b1;
            end else begin
                if (data_pend) begin
                    bit_pos   = 5'(25 - m_slot);
                    joy_data  = (m_slot >= 2) ? frame_word[bit_pos] : 1'b1;
                    data_pend = 1'b0;
                end
                if (!jc_prev && joy_clk_a) data_pend = 1'b1;
                if (jc_prev && !joy_clk_a) m_slot = (m_slot == 25) ? 0 : m_slot + 1;
                jc_prev = joy_clk_a;
            end
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1, "watchdog");
    end

    // Advance to the next frame_done pulse (sampled on negedges), bounded.
    task automatic wait_frame_done(output int waited);
        waited = 0;
        do begin
            @(negedge clk12);
            waited++;
        end while (!frame_done_a && waited < 2 * FRAME_CYCLES);
        n_cmp++;
        if (!frame_done_a) begin
            n_bad++;
            $display("FAIL frame_done_timeout: no pulse after %0d cycles, required within %0d", waited, 2 * FRAME_CYCLES);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk12);
        n_cmp++;
        if ({joystick1_a, joystick2_a} !== 24'hFFFFFF) begin
            n_bad++;
            $display("FAIL reset_words_a: got %h required ffffff", {joystick1_a, joystick2_a});
        end
        n_cmp++;
        if ({joystick1_b, joystick2_b} !== 24'hFFFFFF) begin
            n_bad++;
            $display("FAIL reset_words_b: got %h required ffffff", {joystick1_b, joystick2_b});
        end
        n_cmp++;
        if ({joy_clk_a, joy_load_a, frame_done_a} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl_a: clk/load/done got %b required 000", {joy_clk_a, joy_load_a, frame_done_a});
        end
        n_cmp++;
        if ({joy_clk_b, joy_load_b, frame_done_b} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl_b: clk/load/done got %b required 000", {joy_clk_b, joy_load_b, frame_done_b});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        int waited;
        int load_low;
        frame_word = 24'hFFFFFF;
        // Released at a negedge: tick 52 (end of slot 25) is edge 1456, COMMIT
        // fills the next cycle, frame_done is registered on edge 1457.
        wait_frame_done(waited);
        n_cmp++;
        if (waited != FRAME_CYCLES + 1) begin
            n_bad++;
            $display("FAIL first_frame_done: got %0d cycles required %0d", waited, FRAME_CYCLES + 1);
        end
        for (int f = 0; f < 2; f++) begin
            n_cmp++;
            if ({joystick1_a, joystick2_a, joystick1_b, joystick2_b} !== 48'hFFFFFFFFFFFF) begin
                n_bad++;
                $display("FAIL idle_words: got %h %h %h %h required fff", joystick1_a, joystick2_a, joystick1_b, joystick2_b);
            end
            n_cmp++;
            if (frame_done_b !== 1'b1) begin
                n_bad++;
                $display("FAIL idle_done_b: got %b required 1", frame_done_b);
            end
            load_low = joy_load_a ? 0 : 1;
            for (int i = 1; i < FRAME_CYCLES; i++) begin
                @(negedge clk12);
                if (!joy_load_a) load_low++;
                if (i == 1) begin
                    n_cmp++;
                    if (frame_done_a !== 1'b0) begin
                        n_bad++;
                        $display("FAIL done_width: got %b one cycle later, required 0", frame_done_a);
                    end
                end
            end
            @(negedge clk12);
            n_cmp++;
            if (frame_done_a !== 1'b1) begin
                n_bad++;
                $display("FAIL frame_period: frame_done got %b at %0d cycles, required 1", frame_done_a, FRAME_CYCLES);
            end
            n_cmp++;
            if (load_low != 2 * CLK_DIV) begin
                n_bad++;
                $display("FAIL load_width: got %0d low cycles required %0d", load_low, 2 * CLK_DIV);
            end
        end
    endtask

    task automatic test_bit_map();
        int          waited;
        logic [23:0] vec  [4];
        logic [11:0] exp1 [4];
        logic [11:0] exp2 [4];
        vec  = '{24'h5A3C96, 24'h800001, 24'h00C000, 24'h000F00};
        exp1 = '{12'hA5A,    12'h180,    12'h000,    12'h000};
        exp2 = '{12'h4BC,    12'h000,    12'h140,    12'h00F};
        for (int v = 0; v < 4; v++) begin
            frame_word = vec[v];
            wait_frame_done(waited);
            n_cmp++;
            if (joystick1_a !== exp1[v] || joystick2_a !== exp2[v]) begin
                n_bad++;
                $display("FAIL bit_map[%0d] %h: got %h/%h required %h/%h", v, vec[v], joystick1_a, joystick2_a, exp1[v], exp2[v]);
            end
        end
    endtask

    task automatic test_sample_point();
        int          waited;
        logic [23:0] vec [2];
        logic [11:0] exp [2];
        vec = '{24'hAAAAAA, 24'h555555};
        exp = '{12'h72A,    12'h8D5};
        for (int v = 0; v < 2; v++) begin
            frame_word = vec[v];
            wait_frame_done(waited);
            n_cmp++;
            if (joystick1_a !== exp[v] || joystick2_a !== exp[v]) begin
                n_bad++;
                $display("FAIL sample_point[%0d] %h: got %h/%h required %h/%h", v, vec[v], joystick1_a, joystick2_a, exp[v], exp[v]);
            end
        end
    endtask

    task automatic test_debounce_accept();
        int          waited;
        logic [11:0] exp_b [7];
        logic [11:0] exp_a [7];
        exp_b = '{12'hFFF, 12'hFFF, 12'hFFE, 12'hFFE, 12'hFFE, 12'hFFE, 12'hFFF};
        exp_a = '{12'hFFE, 12'hFFE, 12'hFFE, 12'hFFE, 12'hFFF, 12'hFFF, 12'hFFF};
        frame_word = 24'hFFFFFF;
        repeat (4) wait_frame_done(waited);
        n_cmp++;
        if ({joystick1_b, joystick2_b} !== 24'hFFFFFF) begin
            n_bad++;
            $display("FAIL settle_b: got %h/%h required fff/fff", joystick1_b, joystick2_b);
        end
        // joystick1[0] is slot 9, chain bit 16: low for frames 0..3, high after.
        for (int f = 0; f < 7; f++) begin
            frame_word = (f < 4) ? 24'hFEFFFF : 24'hFFFFFF;
            wait_frame_done(waited);
            n_cmp++;
            if (joystick1_b !== exp_b[f] || joystick1_a !== exp_a[f]) begin
                n_bad++;
                $display("FAIL deb_accept frame %0d: got b=%h a=%h required b=%h a=%h", f, joystick1_b, joystick1_a, exp_b[f], exp_a[f]);
            end
        end
    endtask

    task automatic test_debounce_reject();
        int         waited;
        logic [6:0] low_pat;
        // joystick2[4] is slot 13, chain bit 12: low pattern 1,1,0,1,1,0,0.
        low_pat = 7'b0011011;
        for (int f = 0; f < 7; f++) begin
            frame_word = low_pat[f] ? 24'hFFEFFF : 24'hFFFFFF;
            wait_frame_done(waited);
            n_cmp++;
            if (joystick2_b !== 12'hFFF || joystick2_a !== (low_pat[f] ? 12'hFEF : 12'hFFF)) begin
                n_bad++;
                $display("FAIL deb_reject frame %0d: got b=%h a=%h required b=fff a=%h", f, joystick2_b, joystick2_a, low_pat[f] ? 12'hFEF : 12'hFFF);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int waited;
        frame_word = 24'h000000;
        for (int f = 0; f < 3; f++) begin
            wait_frame_done(waited);
            n_cmp++;
            if ({joystick1_b, joystick2_b} !== ((f == 2) ? 24'h000000 : 24'hFFFFFF)) begin
                n_bad++;
                $display("FAIL pre_reset frame %0d: got %h/%h", f, joystick1_b, joystick2_b);
            end
        end
        waited = 0;
        while (m_slot != 12 && waited < 2 * FRAME_CYCLES) begin
            @(negedge clk12);
            waited++;
        end
        n_cmp++;
        if (m_slot != 12) begin
            n_bad++;
            $display("FAIL slot12_timeout: slot got %0d required 12", m_slot);
        end
        repeat (5) @(negedge clk12);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({joystick1_a, joystick2_a, joystick1_b, joystick2_b} !== 48'hFFFFFFFFFFFF) begin
            n_bad++;
            $display("FAIL mid_reset_words: got %h %h %h %h required fff", joystick1_a, joystick2_a, joystick1_b, joystick2_b);
        end
        n_cmp++;
        if ({joy_clk_a, joy_load_a, frame_done_a} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_reset_ctrl: clk/load/done got %b required 000", {joy_clk_a, joy_load_a, frame_done_a});
        end
        repeat (3) @(negedge clk12);
        rst_n = 1'b1;
        wait_frame_done(waited);
        n_cmp++;
        if (waited != FRAME_CYCLES + 1) begin
            n_bad++;
            $display("FAIL post_reset_frame: got %0d cycles required %0d", waited, FRAME_CYCLES + 1);
        end
        n_cmp++;
        if ({joystick1_a, joystick2_a} !== 24'h000000 || {joystick1_b, joystick2_b} !== 24'hFFFFFF) begin
            n_bad++;
            $display("FAIL post_reset_f0: got a=%h/%h b=%h/%h required a=000/000 b=fff/fff", joystick1_a, joystick2_a, joystick1_b, joystick2_b);
        end
        wait_frame_done(waited);
        n_cmp++;
        if ({joystick1_b, joystick2_b} !== 24'hFFFFFF) begin
            n_bad++;
            $display("FAIL post_reset_f1: got %h/%h required fff/fff", joystick1_b, joystick2_b);
        end
        wait_frame_done(waited);
        n_cmp++;
        if ({joystick1_b, joystick2_b} !== 24'h000000) begin
            n_bad++;
            $display("FAIL post_reset_f2: got %h/%h required 000/000", joystick1_b, joystick2_b);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_bit_map();
        test_sample_point();
        test_debounce_accept();
        test_debounce_reject();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
